// File: rtl/wb_bus_arbiter_if.sv
// Arbiter bundle: per-master request lines, slave termination, grant and
// hold/watchdog status.
//   m_cyc_i, m_stb_i       per-master cycle request / strobe
//   bus_ack_i/err_i/rty_i  termination from the decoded slave side
//   grant_o, grant_idx_o   one-hot grant and binary owner index
//   bus_hold, bus_hold_ack quiesce request / acknowledge
//   timeout_err_o          watchdog error pulse for the owner
interface wb_bus_arbiter_if #(
   parameter int unsigned MASTERS   = 2,
   parameter int unsigned IDX_WIDTH = (MASTERS > 1) ? $clog2(MASTERS) : 1
);
   logic [MASTERS-1:0]   m_cyc_i;
   logic [MASTERS-1:0]   m_stb_i;
   logic                 bus_ack_i;
   logic                 bus_err_i;
   logic                 bus_rty_i;
   logic [MASTERS-1:0]   grant_o;
   logic [IDX_WIDTH-1:0] grant_idx_o;
   logic                 bus_hold;
   logic                 bus_hold_ack;
   logic                 timeout_err_o;

   // Arbiter side
   modport slave (
      input  m_cyc_i, m_stb_i, bus_ack_i, bus_err_i, bus_rty_i, bus_hold,
      output grant_o, grant_idx_o, bus_hold_ack, timeout_err_o
   );

   // Requester / environment side
   modport master (
      output m_cyc_i, m_stb_i, bus_ack_i, bus_err_i, bus_rty_i, bus_hold,
      input  grant_o, grant_idx_o, bus_hold_ack, timeout_err_o
   );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Round-robin owner arbiter for a shared Wishbone B3 bus path, with a
// bus_hold quiesce handshake and a per-access termination watchdog.
//   clk_i   bus clock
//   rst_ni  asynchronous active-low reset
//   bus     wb_bus_arbiter_if.slave: requests in, grant/status out (all
//           outputs registered)
module wb_bus_arbiter #(
   parameter int unsigned MASTERS   = 2,
   parameter int unsigned TIMEOUT   = 255,
   parameter int unsigned TO_WIDTH  = 8,
   parameter int unsigned IDX_WIDTH = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   wb_bus_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      HOLD  = 2'd2
   } state_e;

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(MASTERS - 1);
   localparam logic [TO_WIDTH-1:0]  TO_LAST  = TO_WIDTH'(TIMEOUT - 1);

   state_e               state_q, state_d;
   logic [MASTERS-1:0]   grant_q, grant_d;
   logic [IDX_WIDTH-1:0] idx_q, idx_d;
   logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
   logic                 hold_ack_q, hold_ack_d;
   logic                 to_err_q, to_err_d;
   logic [TO_WIDTH-1:0]  cnt_q, cnt_d;

   logic                 any_cyc_c;
   logic                 owner_cyc_c;
   logic                 owner_stb_c;
   logic                 term_c;
   logic [IDX_WIDTH-1:0] owner_next_c;
   logic [IDX_WIDTH-1:0] search_start_c;
   logic                 lo_found_c, hi_found_c;
   logic [IDX_WIDTH-1:0] lo_idx_c, hi_idx_c;
   logic [IDX_WIDTH-1:0] win_idx_c;
   logic [MASTERS-1:0]   win_onehot_c;

   // Owner signals are picked through the one-hot grant, avoiding an index mux
   assign any_cyc_c    = |bus.m_cyc_i;
   assign owner_cyc_c  = |(bus.m_cyc_i & grant_q);
   assign owner_stb_c  = |(bus.m_stb_i & grant_q);
   assign term_c       = bus.bus_ack_i | bus.bus_err_i | bus.bus_rty_i;
   assign owner_next_c = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

   // During a handoff the search starts at the pointer value being written
   assign search_start_c = (state_q == GRANT) ? owner_next_c : ptr_q;

   // Round-robin pick: lowest requester at/after start, else lowest overall
   always_comb begin
      lo_found_c = 1'b0;
      hi_found_c = 1'b0;
      lo_idx_c   = '0;
      hi_idx_c   = '0;
      for (int i = 0; i < int'(MASTERS); i++) begin
         if (bus.m_cyc_i[i]) begin
            if (!lo_found_c) begin
               lo_found_c = 1'b1;
               lo_idx_c   = IDX_WIDTH'(i);
            end
            if (!hi_found_c && (IDX_WIDTH'(i) >= search_start_c)) begin
               hi_found_c = 1'b1;
               hi_idx_c   = IDX_WIDTH'(i);
            end
         end
      end
      win_idx_c    = hi_found_c ? hi_idx_c : lo_idx_c;
      win_onehot_c = MASTERS'(1) << win_idx_c;
   end

   // Next-state, grant and watchdog logic
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      idx_d      = idx_q;
      ptr_d      = ptr_q;
      hold_ack_d = hold_ack_q;
      to_err_d   = 1'b0;
      cnt_d      = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (bus.bus_hold) begin
               state_d    = HOLD;
               hold_ack_d = 1'b1;
            end else if (any_cyc_c) begin
               state_d = GRANT;
               grant_d = win_onehot_c;
               idx_d   = win_idx_c;
               cnt_d   = '0;
            end
         end

         GRANT: begin
            if (owner_cyc_c) begin
               // Watchdog only runs while the owner keeps its cycle open
               if (TIMEOUT != 0) begin
                  if (term_c || !owner_stb_c) begin
                     cnt_d = '0;
                  end else if (cnt_q == TO_LAST) begin
                     to_err_d = 1'b1;
                     cnt_d    = '0;
                  end else if (cnt_q != '1) begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end else begin
               ptr_d = owner_next_c;
               cnt_d = '0;
               if (bus.bus_hold) begin
                  state_d    = HOLD;
                  grant_d    = '0;
                  hold_ack_d = 1'b1;
               end else if (any_cyc_c) begin
                  grant_d = win_onehot_c;
                  idx_d   = win_idx_c;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end
         end

         HOLD: begin
            if (!bus.bus_hold) begin
               state_d    = IDLE;
               hold_ack_d = 1'b0;
            end
         end

         default: begin
            state_d    = IDLE;
            grant_d    = '0;
            hold_ack_d = 1'b0;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         idx_q      <= '0;
         ptr_q      <= '0;
         hold_ack_q <= 1'b0;
         to_err_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         idx_q      <= idx_d;
         ptr_q      <= ptr_d;
         hold_ack_q <= hold_ack_d;
         to_err_q   <= to_err_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.grant_o       = grant_q;
   assign bus.grant_idx_o   = idx_q;
   assign bus.bus_hold_ack  = hold_ack_q;
   assign bus.timeout_err_o = to_err_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: directed vector table on a
// 2-master instance, hand-written round-robin / watchdog / hold sequences,
// and randomized traffic on a 4-master instance against a reference model.
`timescale 1ns/1ps
module tb_wb_bus_arbiter;

   localparam int WD_T = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   wb_bus_arbiter_if #(.MASTERS(2)) if2 ();
   wb_bus_arbiter_if #(.MASTERS(4)) if4 ();
   wb_bus_arbiter_if #(.MASTERS(2)) if0 ();
   wb_bus_arbiter_if #(.MASTERS(1)) if1 ();

   wb_bus_arbiter #(.MASTERS(2), .TIMEOUT(255), .TO_WIDTH(8)) u_arb2 (
      .clk_i(clk), .rst_ni(rst_n), .bus(if2));
   wb_bus_arbiter #(.MASTERS(4), .TIMEOUT(WD_T), .TO_WIDTH(3)) u_arb4 (
      .clk_i(clk), .rst_ni(rst_n), .bus(if4));
   wb_bus_arbiter #(.MASTERS(2), .TIMEOUT(0), .TO_WIDTH(8)) u_arb0 (
      .clk_i(clk), .rst_ni(rst_n), .bus(if0));
   wb_bus_arbiter #(.MASTERS(1), .TIMEOUT(3), .TO_WIDTH(2)) u_arb1 (
      .clk_i(clk), .rst_ni(rst_n), .bus(if1));

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic [1:0] cyc;
      logic       hold;
      logic [1:0] grant;
      logic       idx;
      logic       ack;
   } vec_t;

   vec_t tbl[$];

   // Reference model state for the 4-master instance
   int   mo_owner;
   int   mo_ptr;
   int   mo_last;
   int   mo_wait;
   logic mo_hold;
   logic mo_pulse;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [1:0] cyc, input logic hold, input logic [1:0] grant,
                      input logic idx, input logic ack);
      vec_t v;
      v.cyc = cyc; v.hold = hold; v.grant = grant; v.idx = idx; v.ack = ack;
      tbl.push_back(v);
   endtask

   task automatic clear_inputs();
      if2.m_cyc_i = '0; if2.m_stb_i = '0; if2.bus_hold = 1'b0;
      if2.bus_ack_i = 1'b0; if2.bus_err_i = 1'b0; if2.bus_rty_i = 1'b0;
      if4.m_cyc_i = '0; if4.m_stb_i = '0; if4.bus_hold = 1'b0;
      if4.bus_ack_i = 1'b0; if4.bus_err_i = 1'b0; if4.bus_rty_i = 1'b0;
      if0.m_cyc_i = '0; if0.m_stb_i = '0; if0.bus_hold = 1'b0;
      if0.bus_ack_i = 1'b0; if0.bus_err_i = 1'b0; if0.bus_rty_i = 1'b0;
      if1.m_cyc_i = '0; if1.m_stb_i = '0; if1.bus_hold = 1'b0;
      if1.bus_ack_i = 1'b0; if1.bus_err_i = 1'b0; if1.bus_rty_i = 1'b0;
   endtask

   // First requester at or after start, wrapping modulo 4
   function automatic int rr_pick(input int start, input logic [3:0] cyc);
      for (int i = 0; i < 4; i++) begin
         if (cyc[(start + i) % 4]) return (start + i) % 4;
      end
      return -1;
   endfunction

   // Predicts the arbiter's registered outputs after the coming edge
   task automatic model_step(input logic [3:0] cyc, input logic [3:0] stb,
                             input logic term, input logic hold);
      mo_pulse = 1'b0;
      if (mo_hold) begin
         if (!hold) mo_hold = 1'b0;
      end else if (mo_owner < 0) begin
         if (hold) mo_hold = 1'b1;
         else if (cyc != 4'b0) begin
            mo_owner = rr_pick(mo_ptr, cyc);
            mo_last  = mo_owner;
            mo_wait  = 0;
         end
      end else if (cyc[mo_owner]) begin
         // Count consecutive stalled strobe cycles; fire after WD_T of them
         if (term || !stb[mo_owner]) mo_wait = 0;
         else begin
            mo_wait++;
            if (mo_wait == WD_T) begin
               mo_pulse = 1'b1;
               mo_wait  = 0;
            end
         end
      end else begin
         mo_ptr = (mo_owner + 1) % 4;
         if (hold) begin
            mo_owner = -1;
            mo_hold  = 1'b1;
         end else if (cyc != 4'b0) begin
            mo_owner = rr_pick(mo_ptr, cyc);
            mo_last  = mo_owner;
            mo_wait  = 0;
         end else begin
            mo_owner = -1;
         end
      end
   endtask

   initial begin
      logic [3:0] cyc_r;
      logic       hold_r;
      logic [3:0] f;
      int         o;

      // cyc, hold -> grant, idx, hold_ack (after the edge)
      add(2'b11, 0, 2'b01, 0, 0);
      for (int i = 0; i < 7; i++) add(2'b11, 0, 2'b01, 0, 0);
      add(2'b10, 0, 2'b10, 1, 0);
      add(2'b10, 1, 2'b10, 1, 0);
      add(2'b11, 1, 2'b10, 1, 0);
      add(2'b01, 1, 2'b00, 1, 1);
      add(2'b01, 1, 2'b00, 1, 1);
      add(2'b01, 0, 2'b00, 1, 0);
      add(2'b01, 0, 2'b01, 0, 0);
      add(2'b00, 0, 2'b00, 0, 0);
      add(2'b11, 0, 2'b10, 1, 0);
      add(2'b01, 0, 2'b01, 0, 0);
      add(2'b11, 0, 2'b01, 0, 0);
      add(2'b10, 0, 2'b10, 1, 0);
      add(2'b01, 0, 2'b01, 0, 0);
      add(2'b10, 0, 2'b10, 1, 0);
      add(2'b00, 0, 2'b00, 1, 0);
      add(2'b11, 0, 2'b01, 0, 0);
      add(2'b00, 0, 2'b00, 0, 0);
      add(2'b11, 1, 2'b00, 0, 1);
      add(2'b11, 0, 2'b00, 0, 0);
      add(2'b11, 0, 2'b10, 1, 0);
      add(2'b00, 0, 2'b00, 1, 0);

      // Reset with requests pending
      rst_n = 1'b0;
      clear_inputs();
      if2.m_cyc_i = 2'b11;
      step(); step(); step();
      chk("rst_grant", 32'(if2.grant_o), 32'd0);
      chk("rst_idx", 32'(if2.grant_idx_o), 32'd0);
      chk("rst_hold_ack", 32'(if2.bus_hold_ack), 32'd0);
      chk("rst_terr", 32'(if2.timeout_err_o), 32'd0);
      chk("rst_grant4", 32'(if4.grant_o), 32'd0);
      rst_n = 1'b1;

      // Directed table on the 2-master instance
      foreach (tbl[i]) begin
         if2.m_cyc_i  = tbl[i].cyc;
         if2.bus_hold = tbl[i].hold;
         step();
         chk($sformatf("tbl%0d_grant", i), 32'(if2.grant_o), 32'(tbl[i].grant));
         chk($sformatf("tbl%0d_idx", i), 32'(if2.grant_idx_o), 32'(tbl[i].idx));
         chk($sformatf("tbl%0d_hack", i), 32'(if2.bus_hold_ack), 32'(tbl[i].ack));
         chk($sformatf("tbl%0d_terr", i), 32'(if2.timeout_err_o), 32'd0);
      end
      if2.m_cyc_i = '0;

      // Round robin, 4 masters, each owner drops cyc after 3 granted cycles
      f = 4'b1111;
      if4.m_cyc_i = f;
      step();
      for (int k = 0; k < 5; k++) begin
         o = k % 4;
         chk($sformatf("rr%0d_c1", k), 32'(if4.grant_o), 32'(1) << o);
         chk($sformatf("rr%0d_idx", k), 32'(if4.grant_idx_o), 32'(o));
         step();
         chk($sformatf("rr%0d_c2", k), 32'(if4.grant_o), 32'(1) << o);
         step();
         chk($sformatf("rr%0d_c3", k), 32'(if4.grant_o), 32'(1) << o);
         if4.m_cyc_i = f & ~(4'(1) << o);
         step();
         if4.m_cyc_i = f;
      end
      if4.m_cyc_i = '0;
      step(); step();
      chk("rr_idle", 32'(if4.grant_o), 32'd0);

      // Watchdog, TIMEOUT=4: stalled strobe, with an ack on a 4th wait cycle
      if4.m_cyc_i = 4'b0001;
      if4.m_stb_i = 4'b0001;
      step();
      chk("wd_grant", 32'(if4.grant_o), 32'd1);
      chk("wd_enter", 32'(if4.timeout_err_o), 32'd0);
      for (int j = 1; j <= 20; j++) begin
         if4.bus_ack_i = (j == 16);
         step();
         chk($sformatf("wd_pulse_%0d", j), 32'(if4.timeout_err_o),
             32'((j % 4 == 0) && (j != 16)));
         chk($sformatf("wd_keep_%0d", j), 32'(if4.grant_o), 32'd1);
      end
      if4.bus_ack_i = 1'b0;
      if4.m_cyc_i   = '0;
      if4.m_stb_i   = '0;
      step();
      chk("wd_release", 32'(if4.grant_o), 32'd0);
      chk("wd_release_terr", 32'(if4.timeout_err_o), 32'd0);

      // TIMEOUT=0: long stall never trips and the grant stays put
      if0.m_cyc_i = 2'b01;
      if0.m_stb_i = 2'b01;
      step();
      for (int j = 0; j < 1000; j++) begin
         step();
         chk("nowd_terr", 32'(if0.timeout_err_o), 32'd0);
         chk("nowd_grant", 32'(if0.grant_o), 32'd1);
      end
      if0.m_cyc_i = '0;
      if0.m_stb_i = '0;

      // Single master: repeated grants, index stays 0
      if1.m_cyc_i = 1'b1;
      step();
      chk("m1_grant_a", 32'(if1.grant_o), 32'd1);
      step();
      chk("m1_grant_b", 32'(if1.grant_o), 32'd1);
      if1.m_cyc_i = 1'b0;
      step();
      chk("m1_drop", 32'(if1.grant_o), 32'd0);
      if1.m_cyc_i = 1'b1;
      step();
      chk("m1_regrant", 32'(if1.grant_o), 32'd1);
      chk("m1_idx", 32'(if1.grant_idx_o), 32'd0);
      if1.m_cyc_i = 1'b0;

      // Randomized traffic on the 4-master instance against the model
      rst_n = 1'b0;
      clear_inputs();
      step();
      rst_n    = 1'b1;
      mo_owner = -1;
      mo_ptr   = 0;
      mo_last  = 0;
      mo_wait  = 0;
      mo_hold  = 1'b0;
      mo_pulse = 1'b0;
      cyc_r    = '0;
      hold_r   = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(3) == 0) cyc_r[b] = ~cyc_r[b];
         end
         if ($urandom_range(15) == 0) hold_r = ~hold_r;
         if4.m_cyc_i   = cyc_r;
         if4.m_stb_i   = ~(4'($urandom) & 4'($urandom));
         if4.bus_ack_i = ($urandom_range(7) == 0);
         if4.bus_err_i = ($urandom_range(31) == 0);
         if4.bus_rty_i = ($urandom_range(31) == 0);
         if4.bus_hold  = hold_r;
         model_step(if4.m_cyc_i, if4.m_stb_i,
                    if4.bus_ack_i | if4.bus_err_i | if4.bus_rty_i, hold_r);
         step();
         chk("rnd_grant", 32'(if4.grant_o), (mo_owner < 0) ? 32'd0 : (32'(1) << mo_owner));
         chk("rnd_idx", 32'(if4.grant_idx_o), 32'(mo_last));
         chk("rnd_hold_ack", 32'(if4.bus_hold_ack), 32'(mo_hold));
         chk("rnd_terr", 32'(if4.timeout_err_o), 32'(mo_pulse));
         chk("rnd_onehot", 32'($onehot0(if4.grant_o)), 32'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
